cam_rgb444_capture: RTL and testbench

Camera capture stage between the OV7670-style parallel camera pins and the dual-port frame buffer inside `test_cam`. Samples CAM_vsync/CAM_href/CAM_px_data on CAM_pclk and assembles each pair of bytes into one RGB444 pixel. Produces the frame-buffer write port (DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in) for a 160x120 image, with row/column-based addressing and frame status.

---
 rtl/cam_rgb444_capture.sv | 165 ++++++++++++++++
 tb/tb_cam_rgb444_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cam_rgb444_capture.sv
// Camera byte-pair capture: assembles RGB444 pixels from an OV7670-style
// parallel bus and drives a row/column-addressed frame-buffer write port.
module cam_rgb444_capture #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned AW    = 15
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [11:0]   DP_RAM_data_in,
    output logic          frame_done,
    output logic          ovf
);

    localparam int unsigned CW = 8;
    localparam int unsigned RW = 7;

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_START,
        BYTE1,
        BYTE2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [3:0]      red_q, red_d;
    logic            href_q, href_d;
    logic            line_q, line_d;
    logic            regw_q, regw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [11:0]     data_q, data_d;
    logic            frame_done_q, frame_done_d;
    logic            ovf_q, ovf_d;

    logic [AW-1:0]   row_base;
    logic            in_bounds;
    logic            in_frame;
    logic [CW-1:0]   col_inc;
    logic [RW-1:0]   row_inc;

    // row*IMG_W as a constant-folded sum of shifted copies of row
    always_comb begin
        row_base = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            if (((IMG_W >> i) & 32'd1) != 32'd0) begin
                row_base = row_base + (AW'(row_q) << i);
            end
        end
    end

    assign in_bounds = (32'(col_q) < IMG_W) && (32'(row_q) < IMG_H);
    assign in_frame  = (state_q == BYTE1) || (state_q == BYTE2);
    assign col_inc   = (col_q == '1) ? col_q : col_q + CW'(1);
    assign row_inc   = (row_q == '1) ? row_q : row_q + RW'(1);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        red_d        = red_q;
        href_d       = CAM_href;
        line_d       = line_q;
        regw_d       = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        ovf_d        = ovf_q;

        // end of a line that carried data advances to the next row
        if (in_frame && href_q && !CAM_href && line_q) begin
            row_d  = row_inc;
            col_d  = '0;
            line_d = 1'b0;
        end

        case (state_q)
            WAIT_VS: begin
                if (CAM_vsync) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!CAM_vsync) begin
                    row_d   = '0;
                    col_d   = '0;
                    ovf_d   = 1'b0;
                    line_d  = 1'b0;
                    state_d = BYTE1;
                end
            end
            BYTE1: begin
                if (CAM_vsync) begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_START;
                end else if (CAM_href) begin
                    red_d   = CAM_px_data[3:0];
                    line_d  = 1'b1;
                    state_d = BYTE2;
                end
            end
            BYTE2: begin
                if (CAM_vsync) begin
                    red_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = WAIT_START;
                end else if (CAM_href) begin
                    line_d = 1'b1;
                    if (in_bounds) begin
                        regw_d = 1'b1;
                        addr_d = row_base + AW'(col_q);
                        data_d = {red_q, CAM_px_data};
                    end else begin
                        ovf_d = 1'b1;
                    end
                    col_d   = col_inc;
                    state_d = BYTE1;
                end else begin
                    red_d   = '0;
                    state_d = BYTE1;
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            state_q      <= WAIT_VS;
            col_q        <= '0;
            row_q        <= '0;
            red_q        <= '0;
            href_q       <= 1'b0;
            line_q       <= 1'b0;
            regw_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            red_q        <= red_d;
            href_q       <= href_d;
            line_q       <= line_d;
            regw_q       <= regw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign DP_RAM_regW    = regw_q;
    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign frame_done     = frame_done_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_cam_rgb444_capture.sv
// Directed bench for cam_rgb444_capture: per-cycle vector table plus
// whole-frame, overflow and reset sequences checked against hand-derived values.
module tb_cam_rgb444_capture;

    logic        CAM_pclk = 1'b0;
    logic        rst = 1'b1;
    logic        CAM_vsync = 1'b0;
    logic        CAM_href = 1'b0;
    logic [7:0]  CAM_px_data = 8'h00;
    logic        DP_RAM_regW;
    logic [14:0] DP_RAM_addr_in;
    logic [11:0] DP_RAM_data_in;
    logic        frame_done;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [26:0] wq[$];
    int          fd_cnt = 0;

    typedef struct {
        logic        vs;
        logic        hr;
        logic [7:0]  d;
        logic        w;
        logic [14:0] a;
        logic [11:0] dat;
        logic        fd;
        logic        ov;
    } vec_t;

    vec_t vecs[20];

    cam_rgb444_capture dut (
        .CAM_pclk      (CAM_pclk),
        .rst           (rst),
        .CAM_vsync     (CAM_vsync),
        .CAM_href      (CAM_href),
        .CAM_px_data   (CAM_px_data),
        .DP_RAM_regW   (DP_RAM_regW),
        .DP_RAM_addr_in(DP_RAM_addr_in),
        .DP_RAM_data_in(DP_RAM_data_in),
        .frame_done    (frame_done),
        .ovf           (ovf)
    );

    always #5 CAM_pclk = ~CAM_pclk;

    // record write strobes and frame_done pulses mid-cycle
    always @(negedge CAM_pclk) begin
        if (DP_RAM_regW === 1'b1) wq.push_back({DP_RAM_addr_in, DP_RAM_data_in});
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge CAM_pclk);
        CAM_vsync   = vs;
        CAM_href    = hr;
        CAM_px_data = d;
        @(posedge CAM_pclk);
        #1;
    endtask

    task automatic send_line(input logic vs, input int n, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < n; i++) step(vs, 1'b1, (i % 2 == 0) ? b0 : b1);
        for (int i = 0; i < 4; i++) step(vs, 1'b0, 8'h00);
    endtask

    function automatic logic [29:0] outs();
        return {DP_RAM_regW, DP_RAM_addr_in, DP_RAM_data_in, frame_done, ovf};
    endfunction

    initial begin
        int errs;

        //              vs    hr    d      w     a        data     fd    ovf
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 15'd0,   12'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 15'd0,   12'h000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 15'd0,   12'h000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h0A, 1'b0, 15'd0,   12'h000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h5C, 1'b1, 15'd0,   12'hA5C, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h07, 1'b0, 15'd0,   12'hA5C, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 15'd0,   12'hA5C, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 15'd0,   12'hA5C, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h12, 1'b0, 15'd0,   12'hA5C, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h34, 1'b1, 15'd160, 12'h234, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h56, 1'b0, 15'd160, 12'h234, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'h78, 1'b1, 15'd161, 12'h678, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 15'd161, 12'h678, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 15'd161, 12'h678, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 15'd161, 12'h678, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'hFF, 1'b0, 15'd161, 12'h678, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 15'd161, 12'h678, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 8'h09, 1'b0, 15'd161, 12'h678, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 8'hAB, 1'b0, 15'd161, 12'h678, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 15'd161, 12'h678, 1'b0, 1'b0};

        // reset held with href toggling
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i % 2 == 0), 8'hFF);
            check($sformatf("reset_outs[%0d]", i), 32'(outs()), 32'd0);
        end
        check("reset_no_strobes", 32'(wq.size()), 32'd0);
        rst = 1'b0;

        // per-cycle vectors: odd line, second line at 160, vsync in BYTE1 and BYTE2
        wq.delete();
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].vs, vecs[i].hr, vecs[i].d);
            check($sformatf("vec[%0d]", i), 32'(outs()),
                  32'({vecs[i].w, vecs[i].a, vecs[i].dat, vecs[i].fd, vecs[i].ov}));
        end

        // full red frame
        wq.delete();
        fd_cnt = 0;
        step(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < 120; l++) send_line(1'b0, 320, 8'h0F, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        check("red_count", 32'(wq.size()), 32'd19200);
        errs = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i] !== {15'(i), 12'hF00}) errs++;
        end
        check("red_seq_errs", 32'(errs), 32'd0);
        check("red_frame_done", 32'(fd_cnt), 32'd1);
        check("red_ovf", 32'(ovf), 32'd0);

        // overflow line, then normal line, ovf sticky until next frame start
        wq.delete();
        step(1'b0, 1'b0, 8'h00);
        send_line(1'b0, 324, 8'h03, 8'h45);
        check("ovf_count", 32'(wq.size()), 32'd160);
        check("ovf_last", 32'(wq[159]), 32'({15'd159, 12'h345}));
        check("ovf_set", 32'(ovf), 32'd1);
        send_line(1'b0, 320, 8'h03, 8'h45);
        check("ovf_next_line", 32'(wq[160]), 32'({15'd160, 12'h345}));
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("ovf_held_blank", 32'(ovf), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check("ovf_cleared", 32'(ovf), 32'd0);

        // start mid-frame: no capture until vsync pulses
        rst = 1'b1;
        step(1'b0, 1'b1, 8'h0F);
        step(1'b0, 1'b1, 8'h00);
        rst = 1'b0;
        wq.delete();
        fd_cnt = 0;
        send_line(1'b0, 320, 8'h0F, 8'h00);
        send_line(1'b0, 320, 8'h0F, 8'h00);
        check("midstart_no_writes", 32'(wq.size()), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        send_line(1'b0, 4, 8'h01, 8'h23);
        check("midstart_count", 32'(wq.size()), 32'd2);
        check("midstart_w0", 32'(wq[0]), 32'({15'd0, 12'h123}));
        check("midstart_w1", 32'(wq[1]), 32'({15'd1, 12'h123}));
        check("midstart_no_fd", 32'(fd_cnt), 32'd0);

        // reset mid-frame after 500 pixels
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        wq.delete();
        fd_cnt = 0;
        for (int l = 0; l < 3; l++) send_line(1'b0, 320, 8'h0A, 8'hBC);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, (i % 2 == 0) ? 8'h0A : 8'hBC);
        rst = 1'b1;
        step(1'b0, 1'b1, 8'h0A);
        check("rstmid_outs", 32'(outs()), 32'd0);
        step(1'b0, 1'b1, 8'hBC);
        step(1'b0, 1'b1, 8'h0A);
        step(1'b0, 1'b1, 8'hBC);
        check("rstmid_count", 32'(wq.size()), 32'd500);
        check("rstmid_last", 32'(wq[499]), 32'({15'd499, 12'hABC}));
        check("rstmid_no_fd", 32'(fd_cnt), 32'd0);
        rst = 1'b0;
        wq.delete();
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        send_line(1'b0, 2, 8'h0F, 8'h0F);
        check("rstmid_restart", 32'(wq.size() == 1 ? wq[0] : 27'h7FFFFFF), 32'({15'd0, 12'hF0F}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
